// File: rtl/z8_irq_pkg.sv
// ============================================================================
//  Module   : z8_irq_pkg
//  Brief    : Shared constants for the Z8 interrupt controller: SFR addresses,
//             FSM states, priority-group ids and IPR group-order codes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package z8_irq_pkg;

    localparam logic [7:0] SFR_IPR = 8'hF9;
    localparam logic [7:0] SFR_IRQ = 8'hFA;
    localparam logic [7:0] SFR_IMR = 8'hFB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } irq_state_e;

    localparam logic [1:0] GRP_A = 2'd0;  // {IRQ5, IRQ3}
    localparam logic [1:0] GRP_B = 2'd1;  // {IRQ2, IRQ0}
    localparam logic [1:0] GRP_C = 2'd2;  // {IRQ1, IRQ4}

    localparam logic [2:0] IPR_CAB = 3'b001;
    localparam logic [2:0] IPR_ABC = 3'b010;
    localparam logic [2:0] IPR_ACB = 3'b011;
    localparam logic [2:0] IPR_BCA = 3'b100;
    localparam logic [2:0] IPR_CBA = 3'b101;
    localparam logic [2:0] IPR_BAC = 3'b110;

endpackage

`default_nettype wire

// File: rtl/z8_irq_prio.sv
// ============================================================================
//  Module   : z8_irq_prio
//  Brief    : Combinational Z8 priority resolver: eligible sources + IPR to
//             winning source index.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module z8_irq_prio
    import z8_irq_pkg::*;
(
    input  logic [5:0] elig,
    input  logic [5:0] ipr,
    output logic       valid,
    output logic [2:0] idx
);

    function automatic logic [3:0] grp_pick(input logic [1:0] g,
                                            input logic [5:0] e,
                                            input logic [5:0] p);
        logic [2:0] first;
        logic [2:0] second;
        case (g)
            GRP_A:   begin first = p[3] ? 3'd3 : 3'd5; second = p[3] ? 3'd5 : 3'd3; end
            GRP_B:   begin first = p[4] ? 3'd0 : 3'd2; second = p[4] ? 3'd2 : 3'd0; end
            default: begin first = p[5] ? 3'd4 : 3'd1; second = p[5] ? 3'd1 : 3'd4; end
        endcase
        if (e[first])
            return {1'b1, first};
        else if (e[second])
            return {1'b1, second};
        return 4'd0;
    endfunction

    logic [2:0][1:0] w_ord;
    logic            w_code_ok;
    logic [3:0]      w_pick;

    always_comb begin
        w_code_ok = 1'b1;
        w_ord     = '0;
        case (ipr[2:0])
            IPR_CAB: w_ord = {GRP_B, GRP_A, GRP_C};
            IPR_ABC: w_ord = {GRP_C, GRP_B, GRP_A};
            IPR_ACB: w_ord = {GRP_B, GRP_C, GRP_A};
            IPR_BCA: w_ord = {GRP_A, GRP_C, GRP_B};
            IPR_CBA: w_ord = {GRP_A, GRP_B, GRP_C};
            IPR_BAC: w_ord = {GRP_C, GRP_A, GRP_B};
            default: w_code_ok = 1'b0;
        endcase
    end

    // w_ord[0] is the highest-ranked group; scan low-to-high rank so it wins last.
    always_comb begin
        valid  = 1'b0;
        idx    = 3'd0;
        w_pick = 4'd0;
        for (int k = 2; k >= 0; k--) begin
            w_pick = grp_pick(w_ord[k], elig, ipr);
            if (w_pick[3]) begin
                valid = 1'b1;
                idx   = w_pick[2:0];
            end
        end
        if (!w_code_ok)
            valid = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/z8_irq_ctrl.sv
// ============================================================================
//  Module   : z8_irq_ctrl
//  Brief    : Z8 interrupt controller: IRQ/IMR/IPR SFRs, source synchronisers,
//             priority resolution and req/ack handshake to the core.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module z8_irq_ctrl
    import z8_irq_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VECTOR_BASE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irqIn,
    input  logic        regWrite,
    input  logic [7:0]  regAddr,
    input  logic [7:0]  regWdata,
    output logic [7:0]  regRdata,
    output logic        intReq,
    output logic [15:0] intVector,
    input  logic        intAck
);

    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0]  prev_q;
    logic [5:0]  irq_q, irq_d;
    logic [7:0]  imr_q, imr_d;
    logic [5:0]  ipr_q, ipr_d;
    logic [2:0]  sel_q, sel_d;
    logic [15:0] vec_q, vec_d;
    logic        req_q;
    irq_state_e  state_q, state_d;

    logic [5:0]  w_rise;
    logic [5:0]  w_elig;
    logic        w_valid;
    logic [2:0]  w_idx;

    assign w_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign w_elig = irq_q & imr_q[5:0] & {6{imr_q[7]}};

    z8_irq_prio u_prio (
        .elig  (w_elig),
        .ipr   (ipr_q),
        .valid (w_valid),
        .idx   (w_idx)
    );

    always_comb begin
        irq_d   = irq_q;
        imr_d   = imr_q;
        ipr_d   = ipr_q;
        sel_d   = sel_q;
        vec_d   = vec_q;
        state_d = state_q;
        if (regWrite) begin
            case (regAddr)
                SFR_IRQ: irq_d = regWdata[5:0];
                SFR_IMR: imr_d = regWdata;
                SFR_IPR: ipr_d = regWdata[5:0];
                default: ;
            endcase
        end
        irq_d = irq_d | w_rise;
        case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    sel_d   = w_idx;
                    vec_d   = VECTOR_BASE + {12'd0, w_idx, 1'b0};
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // Ack clears after the software/hardware updates so it overrides both.
                if (intAck) begin
                    irq_d[sel_q] = 1'b0;
                    imr_d[7]     = 1'b0;
                    state_d      = ST_ACK;
                end else if (!irq_d[sel_q] || !imr_d[sel_q] || !imr_d[7]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            prev_q  <= '0;
            irq_q   <= '0;
            imr_q   <= '0;
            ipr_q   <= '0;
            sel_q   <= '0;
            vec_q   <= VECTOR_BASE;
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            for (int s = SYNC_STAGES - 1; s > 0; s--)
                sync_q[s] <= sync_q[s-1];
            sync_q[0] <= irqIn;
            prev_q    <= sync_q[SYNC_STAGES-1];
            irq_q     <= irq_d;
            imr_q     <= imr_d;
            ipr_q     <= ipr_d;
            sel_q     <= sel_d;
            vec_q     <= vec_d;
            req_q     <= (state_d == ST_PEND);
            state_q   <= state_d;
        end
    end

    always_comb begin
        regRdata = 8'h00;
        case (regAddr)
            SFR_IPR: regRdata = {2'b00, ipr_q};
            SFR_IRQ: regRdata = {2'b00, irq_q};
            SFR_IMR: regRdata = imr_q;
            default: ;
        endcase
    end

    assign intReq    = req_q;
    assign intVector = vec_q;

endmodule

`default_nettype wire
